// File: rtl/dma_reg_file_pkg.sv
// dma_reg_file_pkg: register map, field layouts and reset constants shared by the DMA register file.
package dma_reg_file_pkg;

    typedef enum logic [3:0] {
        R_CH0_ADDR = 4'h0,
        R_CH0_CNT  = 4'h1,
        R_CH1_ADDR = 4'h2,
        R_CH1_CNT  = 4'h3,
        R_CH2_ADDR = 4'h4,
        R_CH2_CNT  = 4'h5,
        R_CH3_ADDR = 4'h6,
        R_CH3_CNT  = 4'h7,
        R_CMD      = 4'h8,
        R_REQ      = 4'h9,
        R_MASK_BIT = 4'hA,
        R_MODE     = 4'hB,
        R_CLR_PTR  = 4'hC,
        R_MCLR     = 4'hD,
        R_CLR_MASK = 4'hE,
        R_MASK_ALL = 4'hF
    } reg_addr_e;

    typedef logic [7:0] cmd_t;

    // mode byte bits [7:2] as stored per channel
    typedef struct packed {
        logic [1:0] sel;
        logic       dec;
        logic       auto_init;
        logic [1:0] xfer;
    } mode_t;

    typedef struct packed {
        logic [3:0] dreq;
        logic [3:0] tc;
    } status_t;

    localparam logic [3:0] MASK_RST = 4'hF;

    function automatic logic [15:0] put_byte(input logic [15:0] v, input logic hi, input logic [7:0] b);
        return hi ? {b, v[7:0]} : {v[15:8], b};
    endfunction

endpackage

// File: rtl/dma_ch_regs.sv
// dma_ch_regs: one channel's base/current address and count with byte-wide CPU merge.
module dma_ch_regs
    import dma_reg_file_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        wr_addr,
    input  logic        wr_count,
    input  logic        wr_hi,
    input  logic [7:0]  wr_data,
    input  logic        upd,
    input  logic [15:0] upd_addr,
    input  logic [15:0] upd_count,
    input  logic        reload,
    output logic [15:0] base_addr,
    output logic [15:0] curr_addr,
    output logic [15:0] base_count,
    output logic [15:0] curr_count
);

    logic [15:0] addr_src;
    logic [15:0] count_src;

    // reload beats engine write-back; a CPU byte lands on top of either
    assign addr_src  = reload ? base_addr  : upd ? upd_addr  : curr_addr;
    assign count_src = reload ? base_count : upd ? upd_count : curr_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_addr  <= '0;
            curr_addr  <= '0;
            base_count <= '0;
            curr_count <= '0;
        end else if (clr) begin
            base_addr  <= '0;
            curr_addr  <= '0;
            base_count <= '0;
            curr_count <= '0;
        end else begin
            if (wr_addr) base_addr <= put_byte(base_addr, wr_hi, wr_data);
            if (wr_count) base_count <= put_byte(base_count, wr_hi, wr_data);
            curr_addr  <= wr_addr ? put_byte(addr_src, wr_hi, wr_data) : addr_src;
            curr_count <= wr_count ? put_byte(count_src, wr_hi, wr_data) : count_src;
        end
    end

endmodule

// File: rtl/dma_reg_file.sv
// dma_reg_file: CPU-visible register file of a four-channel DMA controller.
module dma_reg_file
    import dma_reg_file_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cs_n,
    input  logic             ior_n,
    input  logic             iow_n,
    input  logic [3:0]       addr_lo,
    input  logic [7:0]       db_in,
    output logic [7:0]       db_out,
    output logic             db_oe,
    output logic [7:0]       cmd_reg,
    output logic [3:0][5:0]  mode_reg,
    output logic [3:0]       mask,
    output logic [3:0]       req,
    output logic [3:0][15:0] base_addr,
    output logic [3:0][15:0] curr_addr,
    output logic [3:0][15:0] base_count,
    output logic [3:0][15:0] curr_count,
    input  logic             upd_en,
    input  logic [1:0]       upd_ch,
    input  logic [15:0]      upd_addr,
    input  logic [15:0]      upd_count,
    input  logic [3:0]       reload,
    input  logic [3:0]       tc_set,
    input  logic [3:0]       dreq_st,
    input  logic [7:0]       temp_data
);

    logic        rd_q, wr_q, acc_q, prev_acc;
    logic        start, rd_start, wr_start, mclr;
    logic        ptr, rd_act, is_ch, sel_cnt;
    logic [1:0]  ch;
    logic [3:0]  tc_bits, tc_nxt, req_nxt, mask_nxt, auto_init;
    logic [7:0]  rd_data, rd_mux;
    logic [15:0] cur_sel;
    mode_t [3:0] mode_q;
    status_t     status;

    assign rd_q     = !cs_n && !ior_n && iow_n;
    assign wr_q     = !cs_n && ior_n && !iow_n;
    assign acc_q    = rd_q || wr_q;
    // prev_acc resets high so a strobe held across reset never starts an access
    assign start    = acc_q && !prev_acc;
    assign rd_start = start && rd_q;
    assign wr_start = start && wr_q;
    assign mclr     = wr_start && addr_lo == R_MCLR;
    assign is_ch    = !addr_lo[3];
    assign ch       = addr_lo[2:1];
    assign sel_cnt  = addr_lo[0];

    assign status   = '{dreq: dreq_st, tc: tc_bits};
    assign cur_sel  = sel_cnt ? curr_count[ch] : curr_addr[ch];
    assign rd_mux   = is_ch ? (ptr ? cur_sel[15:8] : cur_sel[7:0]) :
                      addr_lo == R_CMD ? status :
                      addr_lo == R_MCLR ? temp_data : 8'h00;

    assign db_oe    = rd_act && rd_q;
    assign db_out   = db_oe ? rd_data : 8'h00;
    assign mode_reg = mode_q;
    assign tc_nxt   = (rd_start && addr_lo == R_CMD ? 4'h0 : tc_bits) | tc_set;

    // terminal count is applied after CPU writes so it always lands
    always_comb begin
        req_nxt  = req;
        mask_nxt = mask;
        if (wr_start && addr_lo == R_REQ) req_nxt[db_in[1:0]] = db_in[2];
        if (wr_start && addr_lo == R_MASK_BIT) mask_nxt[db_in[1:0]] = db_in[2];
        if (wr_start && addr_lo == R_CLR_MASK) mask_nxt = 4'h0;
        if (wr_start && addr_lo == R_MASK_ALL) mask_nxt = db_in[3:0];
        req_nxt  = req_nxt & ~tc_set;
        mask_nxt = mask_nxt | (tc_set & ~auto_init);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_acc <= 1'b1;
            ptr      <= 1'b0;
            rd_act   <= 1'b0;
            rd_data  <= 8'h00;
            cmd_reg  <= 8'h00;
            mode_q   <= '0;
            req      <= 4'h0;
            mask     <= MASK_RST;
            tc_bits  <= 4'h0;
        end else if (mclr) begin
            prev_acc <= 1'b1;
            ptr      <= 1'b0;
            rd_act   <= 1'b0;
            rd_data  <= 8'h00;
            cmd_reg  <= 8'h00;
            mode_q   <= '0;
            req      <= 4'h0;
            mask     <= MASK_RST;
            tc_bits  <= 4'h0;
        end else begin
            prev_acc <= acc_q;
            rd_act   <= rd_start || (rd_act && rd_q);
            if (rd_start) rd_data <= rd_mux;
            ptr      <= wr_start && addr_lo == R_CLR_PTR ? 1'b0 : start && is_ch ? !ptr : ptr;
            if (wr_start && addr_lo == R_CMD) cmd_reg <= db_in;
            if (wr_start && addr_lo == R_MODE) mode_q[db_in[1:0]] <= mode_t'(db_in[7:2]);
            req      <= req_nxt;
            mask     <= mask_nxt;
            tc_bits  <= tc_nxt;
        end
    end

    genvar i;
    for (i = 0; i < 4; i++) begin : g_ch
        assign auto_init[i] = mode_q[i].auto_init;
        dma_ch_regs u_regs (
            .clk        (clk),
            .rst_n      (rst_n),
            .clr        (mclr),
            .wr_addr    (wr_start && is_ch && ch == 2'(i) && !sel_cnt),
            .wr_count   (wr_start && is_ch && ch == 2'(i) && sel_cnt),
            .wr_hi      (ptr),
            .wr_data    (db_in),
            .upd        (upd_en && upd_ch == 2'(i)),
            .upd_addr   (upd_addr),
            .upd_count  (upd_count),
            .reload     (reload[i]),
            .base_addr  (base_addr[i]),
            .curr_addr  (curr_addr[i]),
            .base_count (base_count[i]),
            .curr_count (curr_count[i])
        );
    end

endmodule

// File: tb/tb_dma_reg_file.sv
// tb_dma_reg_file: directed and randomized checks of dma_reg_file against a register-level model.
module tb_dma_reg_file;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cs_n = 1'b1, ior_n = 1'b1, iow_n = 1'b1;
    logic [3:0]       addr_lo = 4'h0;
    logic [7:0]       db_in = 8'h00;
    logic [7:0]       db_out;
    logic             db_oe;
    logic [7:0]       cmd_reg;
    logic [3:0][5:0]  mode_reg;
    logic [3:0]       mask, req;
    logic [3:0][15:0] base_addr, curr_addr, base_count, curr_count;
    logic             upd_en = 1'b0;
    logic [1:0]       upd_ch = 2'd0;
    logic [15:0]      upd_addr = 16'h0, upd_count = 16'h0;
    logic [3:0]       reload = 4'h0, tc_set = 4'h0, dreq_st = 4'h0;
    logic [7:0]       temp_data = 8'h00;

    always #5 clk = ~clk;

    dma_reg_file dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .ior_n(ior_n), .iow_n(iow_n),
        .addr_lo(addr_lo), .db_in(db_in), .db_out(db_out), .db_oe(db_oe),
        .cmd_reg(cmd_reg), .mode_reg(mode_reg), .mask(mask), .req(req),
        .base_addr(base_addr), .curr_addr(curr_addr), .base_count(base_count), .curr_count(curr_count),
        .upd_en(upd_en), .upd_ch(upd_ch), .upd_addr(upd_addr), .upd_count(upd_count),
        .reload(reload), .tc_set(tc_set), .dreq_st(dreq_st), .temp_data(temp_data)
    );

    int checks = 0;
    int errors = 0;
    bit rnd_on = 1'b0;

    // model: registers indexed by CPU address 0..7 (even = address, odd = count)
    logic [15:0] m_base [8];
    logic [15:0] m_curr [8];
    logic [5:0]  m_mode [4];
    logic [7:0]  m_cmd, m_rdata;
    logic [3:0]  m_mask, m_req, m_tc;
    logic        m_ptr, m_oe, armed;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 8; r++) begin
            m_base[r] = 16'h0;
            m_curr[r] = 16'h0;
        end
        for (int n = 0; n < 4; n++) m_mode[n] = 6'h0;
        m_cmd = 8'h0; m_rdata = 8'h0; m_mask = 4'hF; m_req = 4'h0; m_tc = 4'h0;
        m_ptr = 1'b0; m_oe = 1'b0; armed = 1'b0;
    endtask

    task automatic step();
        logic rd, wr, st, mc;
        int a;
        logic [15:0] nc [8];
        rd = !cs_n && !ior_n && iow_n;
        wr = !cs_n && ior_n && !iow_n;
        st = (rd || wr) && armed;
        a  = int'(addr_lo);
        mc = 1'b0;
        if (st && rd) begin
            m_rdata = a < 8 ? (m_ptr ? m_curr[a][15:8] : m_curr[a][7:0]) :
                      a == 8 ? {dreq_st, m_tc} : a == 13 ? temp_data : 8'h00;
            m_oe = 1'b1;
        end else begin
            m_oe = m_oe && rd;
        end
        for (int r = 0; r < 8; r++)
            nc[r] = reload[r / 2] ? m_base[r] :
                    (upd_en && int'(upd_ch) == r / 2) ? (r % 2 == 1 ? upd_count : upd_addr) : m_curr[r];
        if (st && rd && a == 8) m_tc = 4'h0;
        m_tc = m_tc | tc_set;
        if (st && wr) begin
            if (a < 8) begin
                if (m_ptr) begin
                    m_base[a][15:8] = db_in;
                    nc[a][15:8] = db_in;
                end else begin
                    m_base[a][7:0] = db_in;
                    nc[a][7:0] = db_in;
                end
            end
            if (a == 8) m_cmd = db_in;
            if (a == 9) m_req[db_in[1:0]] = db_in[2];
            if (a == 10) m_mask[db_in[1:0]] = db_in[2];
            if (a == 11) m_mode[db_in[1:0]] = db_in[7:2];
            if (a == 12) m_ptr = 1'b0;
            if (a == 13) mc = 1'b1;
            if (a == 14) m_mask = 4'h0;
            if (a == 15) m_mask = db_in[3:0];
        end
        if (st && a < 8) m_ptr = !m_ptr;
        for (int r = 0; r < 8; r++) m_curr[r] = nc[r];
        for (int n = 0; n < 4; n++)
            if (tc_set[n]) begin
                m_req[n] = 1'b0;
                if (!m_mode[n][2]) m_mask[n] = 1'b1;
            end
        if (mc) model_reset();
        armed = !(rd || wr);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else step();
    end

    always @(negedge clk) begin : cmp
        logic e_oe;
        e_oe = m_oe && !cs_n && !ior_n && iow_n;
        chk("db_oe", 16'(db_oe), 16'(e_oe));
        chk("db_out", 16'(db_out), 16'(e_oe ? m_rdata : 8'h00));
        chk("cmd_reg", 16'(cmd_reg), 16'(m_cmd));
        chk("mask", 16'(mask), 16'(m_mask));
        chk("req", 16'(req), 16'(m_req));
        for (int n = 0; n < 4; n++) begin
            chk("mode_reg", 16'(mode_reg[n]), 16'(m_mode[n]));
            chk("base_addr", base_addr[n], m_base[2 * n]);
            chk("curr_addr", curr_addr[n], m_curr[2 * n]);
            chk("base_count", base_count[n], m_base[2 * n + 1]);
            chk("curr_count", curr_count[n], m_curr[2 * n + 1]);
        end
    end

    task automatic cyc();
        if (rnd_on) begin
            upd_en    = $urandom_range(0, 7) == 0;
            upd_ch    = 2'($urandom);
            upd_addr  = 16'($urandom);
            upd_count = 16'($urandom);
            reload    = $urandom_range(0, 15) == 0 ? 4'($urandom) : 4'h0;
            tc_set    = $urandom_range(0, 11) == 0 ? 4'($urandom) : 4'h0;
            dreq_st   = 4'($urandom);
            temp_data = 8'($urandom);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d, input int hold);
        cs_n = 1'b0; iow_n = 1'b0; addr_lo = a; db_in = d;
        repeat (hold) cyc();
        iow_n = 1'b1; cs_n = 1'b1;
        cyc();
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] v);
        cs_n = 1'b0; ior_n = 1'b0; addr_lo = a;
        cyc();
        v = db_out;
        cyc();
        ior_n = 1'b1; cs_n = 1'b1;
        cyc();
    endtask

    initial begin
        logic [7:0] v;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();
        chk("reset_mask", 16'(mask), 16'h000F);
        chk("reset_oe", 16'(db_oe), 16'h0000);

        wr(4'hC, 8'h00, 1);
        wr(4'h2, 8'h34, 1);
        wr(4'h2, 8'h12, 1);
        chk("ch1_base_addr", base_addr[1], 16'h1234);
        chk("ch1_curr_addr", curr_addr[1], 16'h1234);
        rd(4'h2, v);
        chk("ch1_read_lo", 16'(v), 16'h0034);
        rd(4'h2, v);
        chk("ch1_read_hi", 16'(v), 16'h0012);

        wr(4'hC, 8'h00, 1);
        wr(4'h0, 8'h11, 10);
        chk("held_write_lo", base_addr[0], 16'h0011);
        wr(4'h0, 8'h22, 1);
        chk("held_write_hi", base_addr[0], 16'h2211);

        wr(4'hB, 8'h02, 1);
        wr(4'h9, 8'h06, 1);
        chk("req_set", 16'(req), 16'h0004);
        wr(4'hE, 8'h00, 1);
        tc_set = 4'b0100;
        cyc();
        tc_set = 4'h0;
        chk("tc_mask", 16'(mask), 16'h0004);
        chk("tc_req", 16'(req), 16'h0000);
        rd(4'h8, v);
        chk("status_tc", 16'(v), 16'h0004);
        rd(4'h8, v);
        chk("status_cleared", 16'(v), 16'h0000);

        wr(4'hF, 8'h0F, 1);
        chk("mask_all", 16'(mask), 16'h000F);
        wr(4'hA, 8'h00, 1);
        chk("mask_bit0", 16'(mask), 16'h000E);
        wr(4'hE, 8'h00, 1);
        chk("mask_clear", 16'(mask), 16'h0000);

        wr(4'hC, 8'h00, 1);
        cs_n = 1'b0; iow_n = 1'b0; addr_lo = 4'h0; db_in = 8'h55;
        upd_en = 1'b1; upd_ch = 2'd0; upd_addr = 16'hAAAA; upd_count = 16'h0000;
        cyc();
        upd_en = 1'b0; iow_n = 1'b1; cs_n = 1'b1;
        cyc();
        chk("upd_vs_cpu", curr_addr[0], 16'hAA55);

        cs_n = 1'b0; ior_n = 1'b0; addr_lo = 4'h8;
        cyc();
        chk("read_oe_on", 16'(db_oe), 16'h0001);
        #2 rst_n = 1'b0;
        #1;
        chk("async_oe_off", 16'(db_oe), 16'h0000);
        chk("async_out_off", 16'(db_out), 16'h0000);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("held_read_after_reset", 16'(db_oe), 16'h0000);
        chk("mask_after_reset", 16'(mask), 16'h000F);
        ior_n = 1'b1; cs_n = 1'b1;
        cyc();

        rnd_on = 1'b1;
        repeat (500) begin
            int k;
            logic [3:0] a;
            a = 4'($urandom);
            if (a == 4'hD && $urandom_range(0, 3) != 0) a = 4'hC;
            k = $urandom_range(0, 9);
            addr_lo = a;
            db_in = 8'($urandom);
            cs_n  = k == 0;
            ior_n = !(k <= 1 || k[0]);
            iow_n = !(k == 1 || (k > 1 && !k[0]));
            repeat ($urandom_range(1, 3)) cyc();
            cs_n = 1'b1; ior_n = 1'b1; iow_n = 1'b1;
            repeat ($urandom_range(1, 2)) cyc();
        end
        rnd_on = 1'b0;
        upd_en = 1'b0; reload = 4'h0; tc_set = 4'h0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_reg_file.md
DMA_REG_FILE -- requirements
Module: dma_reg_file

Interface
REQ-001 clk  input  1  single system clock; all state on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 cs_n  input  1  chip select, active low.
REQ-004 ior_n  input  1  I/O read strobe, active low.
REQ-005 iow_n  input  1  I/O write strobe, active low.
REQ-006 addr_lo  input  4  register address.
REQ-007 db_in  input  8  write data bus.
REQ-008 db_out  output  8  read data; db_oe  output  1  read-drive enable.
REQ-009 cmd_reg  output  8  command register; mode_reg  output  4x6  mode[7:2] per channel; mask  output  4; req  output  4.
REQ-010 base_addr, curr_addr, base_count, curr_count  output  4x16 each  per-channel registers.
REQ-011 upd_en  input  1; upd_ch  input  2; upd_addr, upd_count  input  16 each  engine write-back of current registers.
REQ-012 reload  input  4  per-channel auto-init reload, base to current.
REQ-013 tc_set  input  4  terminal-count pulses; dreq_st  input  4  synchronized request levels; temp_data  input  8.

Function
REQ-014 Access start: first cycle with cs_n=0 and exactly one of ior_n/iow_n low, after a cycle with neither strobe qualified; strobe held low produces no further action.
REQ-015 ior_n=0 and iow_n=0 together: no action; db_oe=0.
REQ-016 Write decode at access start:
- 0x0-0x7: addr 2n = ch n address, 2n+1 = ch n count; writes both base and current.
- 0x8: cmd_reg.
- 0x9: req[db_in[1:0]] = db_in[2].
- 0xA: mask[db_in[1:0]] = db_in[2].
- 0xB: mode_reg[db_in[1:0]] = db_in[7:2].
- 0xC: clear byte pointer.
- 0xD: master clear, equals reset.
- 0xE: mask = 0.
- 0xF: mask = db_in[3:0].
REQ-017 Byte pointer: 0 selects low byte, 1 selects high byte; toggles after every 0x0-0x7 access start, read or write.
REQ-018 Read data latched at access start; db_oe=1 from next cycle until strobe release; db_out=0 when db_oe=0.
- 0x0-0x7: current register byte selected by pointer.
- 0x8: status = {dreq_st, tc_bits}.
- 0xD: temp_data.
- Other addresses: 0x00.
REQ-019 Status read clears tc_bits in the access start cycle; a tc_set in the same cycle wins and the bit stays 1.
REQ-020 tc_set[n]: set tc_bits[n], clear req[n]; if mode_reg[n] auto-init bit (mode bit 4) is 0, also set mask[n].
REQ-021 upd_en loads curr_addr/curr_count[upd_ch]; a same-cycle CPU write to that channel register wins for the byte written; the other byte takes upd data.
REQ-022 reload[n] copies base to current; a same-cycle upd_en to that channel is overridden by reload.
REQ-023 Registers hold value with no wrap or arithmetic; the engine owns increment and decrement.

Reset
REQ-024 rst_n=0 or master clear:
- cmd_reg, mode_reg, req, tc_bits, byte pointer, all base and current registers = 0.
- mask = 4'hF; db_oe=0; db_out=0.
REQ-025 Reset mid-access: outputs clear immediately; a strobe still held after release is not an access start.

Structure
REQ-026 Register address constants, the mode/command/status typedefs and the mask reset value live in the shared DMA package.
REQ-027 Per-channel base/current storage and byte-merge logic form one sub-module, dma_ch_regs, instantiated four times.

Verification
REQ-028 Pointer clear (0xC), write 0x34 then 0x12 to addr 0x2 -> base_addr[1] = curr_addr[1] = 0x1234; next read of 0x2 returns 0x34, then 0x12.
REQ-029 iow_n held low 10 cycles writing 0x0 -> exactly one pointer toggle; a second access writes the high byte.
REQ-030 tc_set=4'b0100 with mode_reg[2] auto-init=0 -> mask[2]=1, req[2]=0; status read returns 0x04 in low nibble, following read returns 0x00.
REQ-031 Write 0x0F to 0xF, write 0x00 to 0xA, write 0x00 to 0xE -> mask = 4'hF, then 4'hE, then 4'h0.
REQ-032 upd_en ch0 data 0xAAAA in same cycle as CPU low-byte write 0x55 to 0x0 -> curr_addr[0] = 0xAA55.
REQ-033 rst_n asserted while ior_n is low -> db_oe drops to 0 asynchronously; after release, mask = 4'hF and no read completes.
